// File: rtl/udp_tx_arbiter_if.sv
// AXI4-Stream bundle shared by the arbiter's source and MAC-side ports.
//   master : drives tvalid/tdata/tkeep/tuser/tlast, receives tready
//   slave  : receives tvalid/tdata/tkeep/tuser/tlast, drives tready
interface udp_tx_arbiter_if #(
  parameter int DW = 64,
  parameter int KW = DW / 8
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tuser;
  logic          tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: frame-level arbiter sharing the MAC TX stream between two
// frame sources. A grant is held from first beat to tlast, followed by a
// programmable idle gap. Frames forwarded per source are counted.
//
// Ports:
//   axis_aclk, axis_areset : clock, async active-high reset
//   s00_axis, s01_axis     : source streams (slave modport)
//   m00_axis               : stream to MAC (master modport)
//   src_en[1:0]            : per-source arbitration enable
//   gap_cycles[15:0]       : idle cycles inserted after each frame
//   pkt_count0/1[31:0]     : wrapping frame counters per source
//   busy                   : high whenever not IDLE
//
// Build option: define UDP_TX_ARB_PRIO_EN for strict priority (source 0
// wins ties); default build uses round-robin.
module udp_tx_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8
) (
  input  logic               axis_aclk,
  input  logic               axis_areset,
  udp_tx_arbiter_if.slave    s00_axis,
  udp_tx_arbiter_if.slave    s01_axis,
  udp_tx_arbiter_if.master   m00_axis,
  input  logic [1:0]         src_en,
  input  logic [15:0]        gap_cycles,
  output logic [31:0]        pkt_count0,
  output logic [31:0]        pkt_count1,
  output logic               busy
);
  localparam int NUM_SRC = 2;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t state, state_d;
  logic   grant, grant_d, pick;
  logic [15:0] gap_cnt;
  logic [NUM_SRC-1:0][31:0] cnt;

  logic [NUM_SRC-1:0] s_vld, s_user, s_last, req;
  logic [NUM_SRC-1:0][C_AXIS_TDATA_WIDTH-1:0] s_data;
  logic [NUM_SRC-1:0][C_AXIS_TKEEP_WIDTH-1:0] s_keep;
  logic fire_last;

  assign s_vld  = {s01_axis.tvalid, s00_axis.tvalid};
  assign s_user = {s01_axis.tuser,  s00_axis.tuser};
  assign s_last = {s01_axis.tlast,  s00_axis.tlast};
  assign s_data = {s01_axis.tdata,  s00_axis.tdata};
  assign s_keep = {s01_axis.tkeep,  s00_axis.tkeep};
  assign req    = s_vld & src_en;

  // Frame ends on the granted source's tlast handshake.
  assign fire_last = (state == SEND) && s_vld[grant] && s_last[grant] && m00_axis.tready;

`ifdef UDP_TX_ARB_PRIO_EN
  assign pick = ~req[0];
`else
  logic last_grant;
  // On a tie the source not served last wins; otherwise the lone requester.
  assign pick = (&req) ? ~last_grant : req[1];

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset)    last_grant <= 1'b1;
    else if (fire_last) last_grant <= grant;
  end
`endif

  always_comb begin
    state_d = state;
    grant_d = grant;
    case (state)
      IDLE: if (|req) begin
        grant_d = pick;
        state_d = SEND;
      end
      SEND: if (fire_last) state_d = (gap_cycles != 16'd0) ? GAP : IDLE;
      GAP:  if (gap_cnt <= 16'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      gap_cnt <= '0;
      cnt     <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      if (fire_last) begin
        gap_cnt    <= gap_cycles;
        cnt[grant] <= cnt[grant] + 32'd1;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
    end
  end

  // Zero-latency forwarding in SEND; everything idles to 0 otherwise.
  always_comb begin
    m00_axis.tvalid = 1'b0;
    m00_axis.tdata  = '0;
    m00_axis.tkeep  = '0;
    m00_axis.tuser  = 1'b0;
    m00_axis.tlast  = 1'b0;
    s00_axis.tready = 1'b0;
    s01_axis.tready = 1'b0;
    if (state == SEND) begin
      m00_axis.tvalid = s_vld[grant];
      m00_axis.tdata  = s_data[grant];
      m00_axis.tkeep  = s_keep[grant];
      m00_axis.tuser  = s_user[grant];
      m00_axis.tlast  = s_last[grant];
      if (grant) s01_axis.tready = m00_axis.tready;
      else       s00_axis.tready = m00_axis.tready;
    end
  end

  assign pkt_count0 = cnt[0];
  assign pkt_count1 = cnt[1];
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter. The reference model works at frame
// level: per-source queues of expected beats, a grant rule, and the
// timing rule "next grant = first cycle with a request at or after
// tlast + gap + 1; first beat one cycle later".
module tb_udp_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        u;
    logic        l;
  } beat_t;

  udp_tx_arbiter_if #(.DW(64)) s0 ();
  udp_tx_arbiter_if #(.DW(64)) s1 ();
  udp_tx_arbiter_if #(.DW(64)) m ();

  logic [1:0]  en;
  logic [15:0] gap;
  logic        m_rdy;
  logic [31:0] c0, c1;
  logic        busy;
  logic [1:0]  vld;
  beat_t       cur [2];

  beat_t drv_q [2][$];
  beat_t exp_q [2][$];

  assign s0.tvalid = vld[0];
  assign s0.tdata  = cur[0].d;
  assign s0.tkeep  = cur[0].k;
  assign s0.tuser  = cur[0].u;
  assign s0.tlast  = cur[0].l;
  assign s1.tvalid = vld[1];
  assign s1.tdata  = cur[1].d;
  assign s1.tkeep  = cur[1].k;
  assign s1.tuser  = cur[1].u;
  assign s1.tlast  = cur[1].l;
  assign m.tready  = m_rdy;

  udp_tx_arbiter dut (
    .axis_aclk   (clk),
    .axis_areset (rst),
    .s00_axis    (s0),
    .s01_axis    (s1),
    .m00_axis    (m),
    .src_en      (en),
    .gap_cycles  (gap),
    .pkt_count0  (c0),
    .pkt_count1  (c1),
    .busy        (busy)
  );

  int vectors = 0, miscompares = 0;
  int n = 0, earliest, gap_end, last_m, cur_src, pw, bif, fid = 0;
  int mc [2];
  bit active, pend;
  int pval = 100;  // percent chance a source presents a pending beat
  int rmode = 0;   // 0: tready=1, 1: toggle, 2: random

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick_w(logic [1:0] r);
`ifdef UDP_TX_ARB_PRIO_EN
    return r[0] ? 0 : 1;
`else
    if (r == 2'b11) return (last_m == 0) ? 1 : 0;
    return r[1] ? 1 : 0;
`endif
  endfunction

  task automatic model_clear();
    active = 0; pend = 0; last_m = 1; bif = 0;
    mc[0] = 0; mc[1] = 0;
    earliest = n; gap_end = -1;
    for (int k = 0; k < 2; k++) begin
      drv_q[k].delete();
      exp_q[k].delete();
    end
    vld = 2'b00;
  endtask

  task automatic enq(int k, int len);
    beat_t b;
    logic [3:0]  tg = 4'(k);
    logic [11:0] f  = 12'(fid);
    for (int i = 0; i < len; i++) begin
      logic [15:0] bi = 16'(i);
      b.d = {tg, f, bi, 32'($urandom())};
      b.k = 8'($urandom());
      b.u = 1'($urandom());
      b.l = (i == len - 1);
      drv_q[k].push_back(b);
      exp_q[k].push_back(b);
    end
    fid++;
  endtask

  // One clock: sample and check at negedge, then drive after posedge.
  task automatic step();
    logic [1:0] hs, req;
    beat_t e;
    @(negedge clk);
    n++;
    if (pend) begin active = 1; cur_src = pw; pend = 0; bif = 0; end
    req = vld & en;
    chk("busy", 64'(busy), 64'(active || (n <= gap_end)));
    chk("m_tvalid", 64'(m.tvalid), 64'(active ? vld[cur_src] : 1'b0));
    chk("s0_tready", 64'(s0.tready), 64'((active && cur_src == 0) ? m_rdy : 1'b0));
    chk("s1_tready", 64'(s1.tready), 64'((active && cur_src == 1) ? m_rdy : 1'b0));
    chk("cnt0", 64'(c0), 64'(mc[0]));
    chk("cnt1", 64'(c1), 64'(mc[1]));
    if (!active) begin
      chk("idle_tdata", m.tdata, 64'd0);
      chk("idle_ctl", 64'({m.tkeep, m.tuser, m.tlast}), 64'd0);
    end
    if (active && m.tvalid && m_rdy) begin
      if (exp_q[cur_src].size() == 0) begin
        chk("unexpected_beat", 64'(cur_src), 64'hFF);
        active = 0;
      end else begin
        e = exp_q[cur_src].pop_front();
        chk("beat_data", m.tdata, e.d);
        chk("beat_ctl", 64'({m.tkeep, m.tuser, m.tlast}), 64'({e.k, e.u, e.l}));
        bif++;
        if (e.l) begin
          mc[cur_src]++;
          last_m   = cur_src;
          active   = 0;
          gap_end  = n + int'(gap);
          earliest = n + int'(gap) + 1;
        end
      end
    end else if (!active && n >= earliest && req != 2'b00) begin
      pend = 1;
      pw   = pick_w(req);
    end
    hs = {s1.tvalid & s1.tready, s0.tvalid & s0.tready};

    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (hs[k]) begin
        void'(drv_q[k].pop_front());
        vld[k] = 1'b0;
      end
      if (!vld[k] && drv_q[k].size() > 0 && int'($urandom_range(99)) < pval) vld[k] = 1'b1;
      if (drv_q[k].size() > 0) cur[k] = drv_q[k][0];
    end
    case (rmode)
      0:       m_rdy = 1'b1;
      1:       m_rdy = ~m_rdy;
      default: m_rdy = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic drain(int bound);
    int i = 0;
    while ((drv_q[0].size() > 0 || drv_q[1].size() > 0 || active || pend) && i < bound) begin
      step();
      i++;
    end
    chk("drain_timeout", 64'(i < bound), 64'd1);
    repeat (12) step();
  endtask

  initial begin
    int before1;
    int i;
    en = 2'b00; gap = 16'd0; m_rdy = 1'b1;
    cur[0] = '0; cur[1] = '0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tvalid", 64'(m.tvalid), 64'd0);
    chk("rst_cnt0", 64'(c0), 64'd0);
    chk("rst_cnt1", 64'(c1), 64'd0);
    chk("rst_tdata", m.tdata, 64'd0);
    rst = 1'b0;

    // Single source, one 6-beat frame
    en = 2'b01;
    enq(0, 6);
    drain(100);
    chk("single_cnt0", 64'(c0), 64'd1);
    chk("single_busy", 64'(busy), 64'd0);

    // Both sources continuously requesting
    en = 2'b11;
    enq(0, 6); enq(1, 6); enq(0, 6); enq(1, 6);
    drain(200);
    chk("rr_cnt0", 64'(c0), 64'd3);
    chk("rr_cnt1", 64'(c1), 64'd2);

    // Inter-frame gap of 10 on back-to-back frames
    en = 2'b01; gap = 16'd10;
    enq(0, 6); enq(0, 6);
    drain(200);

    // Backpressure toggling, src_en[1] cleared mid-frame
    gap = 16'd0; en = 2'b10; rmode = 1;
    before1 = mc[1];
    enq(1, 6); enq(1, 6);
    i = 0;
    while (!(active && bif >= 1) && i < 100) begin step(); i++; end
    chk("bp_start_timeout", 64'(i < 100), 64'd1);
    en = 2'b00;
    repeat (40) step();
    chk("bp_cnt1", 64'(c1), 64'(before1 + 1));
    en = 2'b11; rmode = 0;
    drain(200);

    // Randomized traffic: 1..8-beat frames, bubbles, random ready/gap/enable
    rmode = 2; pval = 70;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(19) == 0) begin
        gap = 16'($urandom_range(6));
        en  = 2'($urandom_range(3));
      end
      for (int k = 0; k < 2; k++)
        if (drv_q[k].size() < 12 && $urandom_range(4) == 0) enq(k, int'($urandom_range(8, 1)));
      step();
    end
    en = 2'b11;
    drain(3000);

    // Reset on beat 3 of a frame, then a tie
    rmode = 0; pval = 100; gap = 16'd0; en = 2'b01;
    enq(0, 6);
    i = 0;
    while (!(active && bif == 2) && i < 100) begin step(); i++; end
    chk("mid_timeout", 64'(i < 100), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(m.tvalid), 64'd0);
    chk("mid_rst_cnt0", 64'(c0), 64'd0);
    chk("mid_rst_cnt1", 64'(c1), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_tdata", m.tdata, 64'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en = 2'b11;
    enq(0, 3); enq(1, 3);
    drain(100);
    chk("tie_cnt0", 64'(c0), 64'd1);
    chk("tie_cnt1", 64'(c1), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/udp_tx_arbiter.md
# udp_tx_arbiter

Packet-level arbiter that shares the 64-bit AXI4-Stream TX port of the 10G Ethernet MAC between two frame sources, e.g. two UDP frame generators. It grants one source at a time and holds the grant for a whole frame, from first beat to `tlast`. After each frame it enforces a programmable inter-frame gap. It counts forwarded frames per source for the AXI-Lite status path.

## Interface
Parameters:
- `C_AXIS_TDATA_WIDTH`, 64, data width of all streams
- `C_AXIS_TKEEP_WIDTH`, 8, byte-enable width (`C_AXIS_TDATA_WIDTH/8`)

Ports:
- `axis_aclk`  in  1  single clock for all logic
- `axis_areset`  in  1  reset, asynchronous, active-high
- `s00_axis_tvalid / tready / tdata / tkeep / tuser / tlast`  in/out/in/in/in/in  1/1/64/8/1/1  source 0 stream
- `s01_axis_tvalid / tready / tdata / tkeep / tuser / tlast`  in/out/in/in/in/in  1/1/64/8/1/1  source 1 stream
- `m00_axis_tvalid / tready / tdata / tkeep / tuser / tlast`  out/in/out/out/out/out  1/1/64/8/1/1  stream to MAC
- `src_en`  in  2  per-source enable; bit n gates source n at arbitration
- `gap_cycles`  in  16  idle cycles inserted after each frame's `tlast` handshake
- `pkt_count0`, `pkt_count1`  out  32  frames forwarded per source
- `busy`  out  1  high in any state except IDLE

## Operation
States: IDLE, SEND, GAP.

- **IDLE**
  - Request n = `s0n_axis_tvalid & src_en[n]`.
  - If any request is present, register the grant and go to SEND the next cycle.
  - All `tready` outputs are 0 and `m00_axis_tvalid` is 0.
- **Grant selection (round-robin)**
  - If both sources request, the source not granted last wins.
  - `last_grant` resets to 1, so source 0 wins the first tie.
  - If only one source requests, it wins.
- **SEND**
  - The granted source is connected combinationally to `m00`: `tvalid`, `tdata`, `tkeep`, `tuser` and `tlast` forward, and `m00_axis_tready` returns to the granted source's `tready`.
  - The other source's `tready` is 0.
  - On a handshake with `tlast` = 1, increment the granted source's counter and update `last_grant`.
  - Then go to GAP if `gap_cycles` is nonzero, else go to IDLE.
- **GAP**
  - A 16-bit down-counter is loaded with `gap_cycles` on frame end and decrements each cycle.
  - Go to IDLE when it reaches 1.
  - All `tready` outputs are 0 and `m00_axis_tvalid` is 0.
- **Counters**
  - Each is 32-bit and wraps from 0xFFFFFFFF to 0 with no saturation.
- **Boundary conditions**
  - A `src_en` bit cleared mid-frame does not abort the frame in progress; it only blocks future grants.
  - A frame with `tlast` on its first beat is legal: one beat, and the count increments once.
  - A source dropping `tvalid` mid-frame keeps the grant, and `m00_axis_tvalid` follows it low.
  - `gap_cycles` is sampled only at frame end; changes during GAP affect the next frame.
  - Simultaneous new requests during GAP are held and resolved in IDLE.

## Timing
- **Reset**: on assertion, go to IDLE immediately (asynchronously).
  - `last_grant` = 1, counters = 0, `busy` = 0.
  - All `tready` outputs = 0; `m00_axis_tvalid`, `m00_axis_tlast` and `m00_axis_tuser` = 0.
  - `m00_axis_tdata` = 0 and `m00_axis_tkeep` = 0 (data is muxed to 0 when not in SEND).
  - Reset mid-frame truncates the frame; the MAC sees no `tlast`.
- **Grant latency**: 1 cycle from a request seen in IDLE to `m00_axis_tvalid` (if the source holds `tvalid`).
- **Data path in SEND**: zero latency; full throughput of one beat per cycle while `tready` and `tvalid` are high.
- **Frame-to-frame spacing**: minimum of `gap_cycles` + 1 idle cycles on `m00` between a `tlast` handshake and the next first beat (the +1 is the IDLE arbitration cycle).
- **Handshake rules**: AXI4-Stream; `tvalid` never depends on `tready`; the arbiter does not modify beats.

## Configuration
- `UDP_TX_ARB_PRIO_EN`
  - Defined: strict priority replaces round-robin. Source 0 wins every tie; `last_grant` is unused and held at 1.
  - Undefined (default): round-robin as described above.
  - All other behaviour is identical in both cases.

## Test plan
- **Single source**: reset, `src_en`=2'b01, `gap_cycles`=0, s00 sends 6-beat frame with `m00_axis_tready`=1 -> 6 beats on m00 starting 1 cycle after `tvalid`, `tlast` on beat 6, `pkt_count0`=1, `busy` low after.
- **Round-robin**: both sources hold `tvalid` continuously with 6-beat frames, `gap_cycles`=0 -> grant order 0,1,0,1; after 4 frames `pkt_count0`=2, `pkt_count1`=2.
- **Gap**: `gap_cycles`=10, s00 back-to-back frames -> exactly 11 cycles with `m00_axis_tvalid`=0 between `tlast` handshake and next first beat.
- **Backpressure and disable**: `m00_axis_tready` toggled 1,0,1,0 during frame from s01 and `src_en[1]` cleared mid-frame -> all 6 beats delivered in order with no duplication; s01's next pending frame is not granted.
- **Reset mid-frame**: assert `axis_areset` on beat 3 -> same cycle `m00_axis_tvalid`=0 and counters=0; after release, a tie grants source 0 first.
- **Priority (`UDP_TX_ARB_PRIO_EN` defined)**: both sources continuously requesting -> only source 0 granted; `pkt_count1` stays 0.
